// File: rtl/pixel_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_serializer
//  Purpose  : Shifts an 8-pixel character row out one pixel per clock as a
//             3-bit colour index, with conceal/blink/blanking and error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_serializer #(
    parameter int REQUEST_LEAD = 2,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       load,
    input  logic [7:0] row_pixels,
    input  logic [2:0] foreground,
    input  logic [2:0] background,
    input  logic       blink,
    input  logic       conceal,
    input  logic       reveal,
    input  logic       display_enable,
    input  logic       clear_errors,
    output logic [2:0] rgb,
    output logic       request,
    output logic       ready,
    output logic       blink_phase,
    output logic       underrun,
    output logic       overrun
);

    localparam logic [3:0] c_request_at = 4'(REQUEST_LEAD + 1);
    localparam logic [7:0] c_frame_last = 8'(BLINK_FRAMES - 1);

    logic [7:0] r_shreg;
    logic [3:0] r_remaining;
    logic [2:0] r_fg;
    logic [2:0] r_bg;
    logic       r_blk;
    logic       r_con;
    logic [7:0] r_frame_cnt;
    logic       r_blink_phase;
    logic       r_underrun;
    logic       r_overrun;
    logic [2:0] r_rgb;

    logic       w_emit;
    logic       w_ready;
    logic       w_accept;
    logic       w_reject;
    logic       w_hide;
    logic [2:0] w_colour;

    assign w_emit   = (r_remaining != 4'd0);
    assign w_ready  = (r_remaining <= 4'd1);
    assign w_accept = load & w_ready;
    assign w_reject = load & ~w_ready;
    // Colour uses the attributes of the row the pixel belongs to, even on the
    // cycle a new row is being latched.
    assign w_hide   = (r_con & ~reveal) | (r_blk & r_blink_phase);
    assign w_colour = (w_hide | ~r_shreg[7]) ? r_bg : r_fg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg     <= 8'd0;
            r_remaining <= 4'd0;
            r_rgb       <= 3'd0;
        end else begin
            if (w_emit) begin
                r_rgb       <= display_enable ? w_colour : 3'd0;
                r_shreg     <= {r_shreg[6:0], 1'b0};
                r_remaining <= r_remaining - 4'd1;
            end else begin
                r_rgb       <= 3'd0;
            end
            if (w_accept) begin
                r_shreg     <= row_pixels;
                r_remaining <= 4'd8;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fg  <= 3'd0;
            r_bg  <= 3'd0;
            r_blk <= 1'b0;
            r_con <= 1'b0;
        end else if (w_accept) begin
            r_fg  <= foreground;
            r_bg  <= background;
            r_blk <= blink;
            r_con <= conceal;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt   <= 8'd0;
            r_blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (r_frame_cnt == c_frame_last) begin
                r_frame_cnt   <= 8'd0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt   <= r_frame_cnt + 8'd1;
            end
        end
    end

    // A fresh error in the same cycle as clear_errors leaves the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_underrun <= (r_underrun & ~clear_errors) | (~w_emit & display_enable);
            r_overrun  <= (r_overrun & ~clear_errors) | w_reject;
        end
    end

    assign rgb         = r_rgb;
    assign request     = (r_remaining == c_request_at);
    assign ready       = w_ready;
    assign blink_phase = r_blink_phase;
    assign underrun    = r_underrun;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pixel_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_serializer
//  Purpose  : Directed self-checking bench for pixel_serializer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_serializer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_start;
    logic       load;
    logic [7:0] row_pixels;
    logic [2:0] foreground;
    logic [2:0] background;
    logic       blink;
    logic       conceal;
    logic       reveal;
    logic       display_enable;
    logic       clear_errors;
    logic [2:0] rgb;
    logic       request;
    logic       ready;
    logic       blink_phase;
    logic       underrun;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned exp_single[8] = '{7, 1, 7, 1, 1, 1, 7, 7};
    int unsigned exp_ovr[8]    = '{2, 2, 5, 5, 5, 2, 5, 2};

    logic [7:0] s_px [100];
    logic [2:0] s_fg [100];
    logic [2:0] s_bg [100];
    int k, p, cd, nxt, last_req, n_req;

    pixel_serializer #(
        .REQUEST_LEAD(2),
        .BLINK_FRAMES(4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_start    (frame_start),
        .load           (load),
        .row_pixels     (row_pixels),
        .foreground     (foreground),
        .background     (background),
        .blink          (blink),
        .conceal        (conceal),
        .reveal         (reveal),
        .display_enable (display_enable),
        .clear_errors   (clear_errors),
        .rgb            (rgb),
        .request        (request),
        .ready          (ready),
        .blink_phase    (blink_phase),
        .underrun       (underrun),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_row(input logic [7:0] px, input logic [2:0] fg, input logic [2:0] bg,
                             input logic blk, input logic con);
        row_pixels = px;
        foreground = fg;
        background = bg;
        blink      = blk;
        conceal    = con;
        load       = 1'b1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Loads a row from idle with blanking held off during the load cycle,
    // then checks all eight emitted pixels and the request pulse position.
    task automatic play_row(input string tag, input logic [7:0] px, input logic [2:0] fg,
                            input logic [2:0] bg, input logic blk, input logic con,
                            input logic de_run, input logic hidden);
        int unsigned exp;
        display_enable = 1'b0;
        drive_row(px, fg, bg, blk, con);
        tick();
        load = 1'b0;
        check({tag, "_ready"}, ready, 0);
        display_enable = de_run;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!de_run)                 exp = 0;
            else if (hidden || !px[7-i]) exp = bg;
            else                         exp = fg;
            check($sformatf("%s_px%0d", tag, i), rgb, exp);
            check($sformatf("%s_req%0d", tag, i), request, (i == 4) ? 1 : 0);
        end
        display_enable = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; frame_start = 1'b0; load = 1'b0; row_pixels = 8'd0;
        foreground = 3'd0; background = 3'd0; blink = 1'b0; conceal = 1'b0;
        reveal = 1'b0; display_enable = 1'b0; clear_errors = 1'b0;
        tick();
        tick();
        check("rst_rgb", rgb, 0);
        check("rst_ready", ready, 1);
        check("rst_request", request, 0);
        check("rst_blink_phase", blink_phase, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        tick();

        // Single row, then run empty
        drive_row(8'b1010_0011, 3'd7, 3'd1, 1'b0, 1'b0);
        tick();
        load = 1'b0;
        display_enable = 1'b1;
        check("single_ready", ready, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("single_px%0d", i), rgb, exp_single[i]);
            check($sformatf("single_req%0d", i), request, (i == 4) ? 1 : 0);
        end
        check("single_no_underrun", underrun, 0);
        tick();
        check("single_empty_rgb", rgb, 0);
        check("single_underrun", underrun, 1);
        display_enable = 1'b0;
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        check("single_cleared", underrun, 0);

        // Continuous stream driven from the request handshake
        for (int i = 0; i < 100; i++) begin
            s_px[i] = 8'(i * 37 + 91);
            s_fg[i] = 3'(i);
            s_bg[i] = 3'(i + 3);
        end
        drive_row(s_px[0], s_fg[0], s_bg[0], 1'b0, 1'b0);
        tick();
        load = 1'b0;
        display_enable = 1'b1;
        k = 0; p = 0; cd = -1; nxt = 1; last_req = -1; n_req = 0;
        for (int cyc = 1; cyc <= 800; cyc++) begin
            tick();
            load = 1'b0;
            check($sformatf("stream_r%0d_px%0d", k, p), rgb, s_px[k][7-p] ? s_fg[k] : s_bg[k]);
            p++;
            if (p == 8) begin
                p = 0;
                k++;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (nxt < 100) drive_row(s_px[nxt], s_fg[nxt], s_bg[nxt], 1'b0, 1'b0);
                    nxt++;
                    cd = -1;
                end
            end
            if (request) begin
                n_req++;
                if (last_req >= 0) check("stream_req_gap", cyc - last_req, 8);
                last_req = cyc;
                cd = 2;
            end
        end
        display_enable = 1'b0;
        check("stream_requests", n_req, 100);
        check("stream_underrun", underrun, 0);
        check("stream_overrun", overrun, 0);

        // Overrun: second load during the row is rejected
        drive_row(8'hC5, 3'd2, 3'd5, 1'b0, 1'b0);
        tick();
        load = 1'b0;
        display_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) drive_row(8'h3A, 3'd7, 3'd0, 1'b0, 1'b0);
            tick();
            load = 1'b0;
            check($sformatf("ovr_px%0d", i), rgb, exp_ovr[i]);
        end
        display_enable = 1'b0;
        check("ovr_flag", overrun, 1);
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        check("ovr_cleared", overrun, 0);
        drive_row(8'h0F, 3'd1, 3'd2, 1'b0, 1'b0);
        tick();
        drive_row(8'hF0, 3'd3, 3'd4, 1'b0, 1'b0);
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        load = 1'b0;
        check("ovr_error_wins", overrun, 1);
        for (int i = 0; i < 10; i++) tick();
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;

        // Conceal / reveal / blanking
        play_row("conceal", 8'hFF, 3'd6, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        reveal = 1'b1;
        play_row("reveal", 8'hFF, 3'd6, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        reveal = 1'b0;
        play_row("blanked", 8'hFF, 3'd6, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check("blanked_underrun", underrun, 0);

        // Blink with a 4-frame half-period
        for (int i = 0; i < 3; i++) pulse_frame();
        check("blink_after3", blink_phase, 0);
        pulse_frame();
        check("blink_after4", blink_phase, 1);
        play_row("blink_on", 8'hFF, 3'd4, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        play_row("blink_plain", 8'hFF, 3'd4, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) pulse_frame();
        check("blink_after7", blink_phase, 1);
        pulse_frame();
        check("blink_after8", blink_phase, 0);

        // Asynchronous reset mid-row
        for (int i = 0; i < 4; i++) pulse_frame();
        check("arst_pre_phase", blink_phase, 1);
        drive_row(8'hFF, 3'd5, 3'd2, 1'b0, 1'b0);
        tick();
        load = 1'b0;
        display_enable = 1'b1;
        tick();
        drive_row(8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        load = 1'b0;
        tick();
        tick();
        check("arst_pre_overrun", overrun, 1);
        check("arst_pre_rgb", rgb, 5);
        #2;
        reset_n = 1'b0;
        display_enable = 1'b0;
        #1;
        check("arst_rgb", rgb, 0);
        check("arst_ready", ready, 1);
        check("arst_request", request, 0);
        check("arst_overrun", overrun, 0);
        check("arst_underrun", underrun, 0);
        check("arst_blink_phase", blink_phase, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        play_row("post_rst", 8'h96, 3'd3, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_serializer.md
# pixel_serializer

Downstream stage of the character generator. Takes one 8-pixel character row plus its colour attributes per load and shifts it out one pixel per clock as a 3-bit colour index for the VGA output stage. Also applies conceal, blink and blanking, and reports data underrun and overrun.

## Interface
- REQUEST_LEAD, 2: number of cycles between the `request` pulse and the cycle in which the row load is expected. Legal range 1..6.
- BLINK_FRAMES, 32: number of frames per blink half-period. Legal range 2..255.

Ports:
- clk  in  1  pixel clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- load  in  1  captures the inputs `row_pixels`, `foreground`, `background`, `blink` and `conceal`.
- row_pixels  in  8  row design; bit 7 is the leftmost pixel. Invert, underline and halftone are already applied upstream.
- foreground  in  3  colour index used for set pixels.
- background  in  3  colour index used for clear pixels.
- blink  in  1  row blinks.
- conceal  in  1  row is concealed.
- reveal  in  1  global override that makes concealed rows visible.
- display_enable  in  1  active-video qualifier for the pixel emitted this cycle.
- clear_errors  in  1  clears the sticky error flags.
- rgb  out  3  registered colour index.
- request  out  1  asks upstream for the next row.
- ready  out  1  a load in this cycle will be accepted.
- blink_phase  out  1  current blink phase; 1 means blinking rows are hidden.
- underrun  out  1  sticky flag: the shifter ran empty.
- overrun  out  1  sticky flag: a load was rejected.

## Operation
State:
- `shreg[7:0]`.
- `remaining[3:0]`, range 0..8: pixels still to be emitted.
- Latched attributes: fg, bg, blk, con.
- Frame counter.
- `blink_phase`, `underrun`, `overrun`.

Combinational outputs:
- `ready` = (remaining <= 1).
- `request` = (remaining == REQUEST_LEAD+1). Because `remaining` falls by one per cycle, this is a one-cycle pulse.

Emission in each cycle, when remaining > 0:
- pixel = shreg[7].
- `shreg` shifts left and `remaining` decrements.
- colour = bg if (con & ~reveal) or (blk & blink_phase); otherwise fg if pixel is 1, bg if pixel is 0.
- `rgb` <= display_enable ? colour : 0.

Emission in each cycle, when remaining == 0:
- `rgb` <= 0.
- `underrun` is set only when display_enable = 1.

Load accepted (load & ready):
- The old last pixel, if any, is emitted this cycle as above.
- Then shreg <= row_pixels, remaining <= 8, and the attributes are latched.
- The first new pixel appears on `rgb` in the following cycle. Rows back-to-back are therefore seamless.

Load rejected (load & ~ready):
- Inputs are ignored, normal emission continues, and `overrun` is set.

Blink:
- Each `frame_start` increments the frame counter.
- When the counter reaches BLINK_FRAMES-1, it wraps to 0 and `blink_phase` toggles.
- `blink_phase` takes effect on the pixel emitted in the cycle after the toggle.

Error flags:
- `clear_errors` clears both flags.
- If a new error occurs in the same cycle as `clear_errors`, the flag ends set (the error wins).

`display_enable` low does not stall the shifter; pixels are consumed and blanked.

## Timing
- Reset values: rgb=0, shreg=0, remaining=0, attributes 0, frame counter 0, blink_phase=0, underrun=0, overrun=0. Consequently ready=1 and request=0.
- Reset asserted mid-row discards the row immediately.
- Latency: load at cycle t → row bit 7 on `rgb` at t+1, bit 0 at t+8.
- Handshake: upstream sees `request` at cycle r and drives `load` at r+REQUEST_LEAD, which is the cycle where remaining==1.
- Load while remaining==0 after an underrun is accepted with no extra bubble beyond the empty cycles already lost.
- First row after reset: load at any time (ready=1). No `request` is issued until a row is in flight.

## Test plan
- **Single row.** Reset, then load row_pixels=8'b1010_0011, fg=3'd7, bg=3'd1, display_enable=1. Required: rgb = 7,1,7,1,1,1,7,7 on cycles t+1..t+8, then rgb=0 and underrun=1 from t+9.
- **Continuous stream, REQUEST_LEAD=2.** Upstream loads exactly 2 cycles after each `request`. Required over 100 rows: no gap between rows, request pulses every 8 cycles, underrun=0, overrun=0.
- **Overrun.** Load a row, then load again at t+3 with different data. Required: overrun=1 and the first row is emitted intact. Then assert clear_errors together with another illegal load; required: overrun stays 1.
- **Conceal and reveal.** Load row 8'hFF with conceal=1, reveal=0. Required: all 8 pixels = bg. Same row with reveal=1: all 8 pixels = fg. Same row with display_enable=0 throughout: rgb=0 and no underrun.
- **Blink, BLINK_FRAMES=4.** Pulse frame_start 3 times. Required: blink_phase toggles to 1 after the 4th pulse. Then a blink=1 row 8'hFF shows bg, and a blink=0 row shows fg. After 4 more pulses blink_phase=0.
- **Asynchronous reset mid-row.** Drop reset_n at t+4. Required: rgb, remaining, flags and blink_phase are 0 immediately, without waiting for a clock edge. Normal operation resumes after reset_n is released.
